// File: rtl/memshare_access_sched.sv
// rtl/memshare_access_sched.sv - registered round-robin scheduler for shared column memory ports
//
// Collects per-requester requests into a pending set and grants up to
// COL_PARALLELISM requesters per transfer accepted by the memory. A grant is
// held stable until mem_ready, and flush clears all pending work at a layer
// boundary.
//
// Optional feature macro: MEMSHARE_RR_EN
//   defined   - round-robin; the priority pointer advances on every accept
//   undefined - fixed priority; index 0 is highest and the pointer stays 0
//
// Ports:
//   sys_clk     - clock, rising edge
//   rst         - asynchronous active-high reset
//   rqst_in     - per-requester request; a high bit sets that pending bit
//   flush       - synchronous clear of pending set and outstanding grant
//   mem_ready   - memory accepts the current grant this cycle
//   grant_vec   - registered grant bits, 1..COL_PARALLELISM set when valid
//   grant_valid - registered, grant_vec is valid
//   pend_cnt    - registered population count of the pending set
//   busy        - registered, scheduler is in GRANT
module memshare_access_sched #(
  parameter int SHARED_GROUP_SIZE = 4,
  parameter int COL_PARALLELISM   = 1
) (
  input  logic                                 sys_clk,
  input  logic                                 rst,
  input  logic [SHARED_GROUP_SIZE-1:0]         rqst_in,
  input  logic                                 flush,
  input  logic                                 mem_ready,
  output logic [SHARED_GROUP_SIZE-1:0]         grant_vec,
  output logic                                 grant_valid,
  output logic [$clog2(SHARED_GROUP_SIZE+1)-1:0] pend_cnt,
  output logic                                 busy
);

  localparam int G  = SHARED_GROUP_SIZE;
  localparam int PW = (G > 1) ? $clog2(G) : 1;
  localparam int CW = $clog2(G + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [G-1:0]    pending_q, pending_d;
  logic [G-1:0]    grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   pend_cnt_q, pend_cnt_d;
  logic [G-1:0]    cand;
  logic [G-1:0]    cand_acc;

  // First COL_PARALLELISM set bits of c, scanning upward from p modulo G.
  function automatic logic [G-1:0] pick(input logic [G-1:0] c, input logic [PW-1:0] p);
    int n;
    int idx;
    pick = '0;
    n    = 0;
    for (int k = 0; k < G; k++) begin
      idx = int'(p) + k;
      if (idx >= G) idx = idx - G;
      if (c[idx[PW-1:0]] && (n < COL_PARALLELISM)) begin
        pick[idx[PW-1:0]] = 1'b1;
        n = n + 1;
      end
    end
  endfunction

  // One past the last granted index in scan order (scan starts at p), mod G.
  function automatic logic [PW-1:0] next_ptr(input logic [G-1:0] s, input logic [PW-1:0] p);
    int idx;
    int nxt;
    nxt = int'(p);
    for (int k = 0; k < G; k++) begin
      idx = int'(p) + k;
      if (idx >= G) idx = idx - G;
      if (s[idx[PW-1:0]]) begin
        nxt = idx + 1;
        if (nxt >= G) nxt = 0;
      end
    end
    next_ptr = nxt[PW-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cand      = pending_q | rqst_in;
    // Retiring bits are dropped first so a same-cycle request re-pends them.
    cand_acc  = (pending_q & ~grant_q) | rqst_in;

    if (flush) begin
      // Pointer survives the flush so fairness carries across layers.
      state_d   = IDLE;
      pending_d = '0;
      grant_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand != '0) begin
            grant_d   = pick(cand, ptr_q);
            pending_d = cand;
            state_d   = GRANT;
          end
        end
        GRANT: begin
          if (!mem_ready) begin
            pending_d = cand;
          end else begin
            pending_d = cand_acc;
`ifdef MEMSHARE_RR_EN
            ptr_d = next_ptr(grant_q, ptr_q);
`else
            ptr_d = '0;
`endif
            if (cand_acc != '0) begin
              grant_d = pick(cand_acc, ptr_d);
            end else begin
              grant_d = '0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          pending_d = '0;
          grant_d   = '0;
        end
      endcase
    end

    pend_cnt_d = CW'($countones(pending_d));
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      pend_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign grant_vec   = grant_q;
  assign grant_valid = (state_q == GRANT);
  assign busy        = (state_q == GRANT);
  assign pend_cnt    = pend_cnt_q;

endmodule

// File: tb/tb_memshare_access_sched.sv
// tb/tb_memshare_access_sched.sv - directed scoreboard bench for memshare_access_sched
module tb_memshare_access_sched;

`ifdef MEMSHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [3:0] gv;
    logic       valid;
    logic [2:0] cnt;
    logic       busy;
    int         sel;
    string      tag;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [3:0] rqst_in;
  logic       flush;
  logic       mem_ready;

  logic [3:0] gv_a, gv_b;
  logic       valid_a, valid_b, busy_a, busy_b;
  logic [2:0] cnt_a, cnt_b;

  int nvec = 0;
  int nmis = 0;
  exp_t exp_q[$];

  always #5 sys_clk = ~sys_clk;

  memshare_access_sched #(.SHARED_GROUP_SIZE(4), .COL_PARALLELISM(1)) dut_a (
    .sys_clk(sys_clk), .rst(rst), .rqst_in(rqst_in), .flush(flush), .mem_ready(mem_ready),
    .grant_vec(gv_a), .grant_valid(valid_a), .pend_cnt(cnt_a), .busy(busy_a)
  );

  memshare_access_sched #(.SHARED_GROUP_SIZE(4), .COL_PARALLELISM(2)) dut_b (
    .sys_clk(sys_clk), .rst(rst), .rqst_in(rqst_in), .flush(flush), .mem_ready(mem_ready),
    .grant_vec(gv_b), .grant_valid(valid_b), .pend_cnt(cnt_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all(input exp_t e);
    logic [3:0] gv;
    logic       vl, bz;
    logic [2:0] ct;
    gv = (e.sel == 1) ? gv_b    : gv_a;
    vl = (e.sel == 1) ? valid_b : valid_a;
    ct = (e.sel == 1) ? cnt_b   : cnt_a;
    bz = (e.sel == 1) ? busy_b  : busy_a;
    chk({e.tag, "_grant_vec"},   {4'b0, gv}, {4'b0, e.gv});
    chk({e.tag, "_grant_valid"}, {7'b0, vl}, {7'b0, e.valid});
    chk({e.tag, "_pend_cnt"},    {5'b0, ct}, {5'b0, e.cnt});
    chk({e.tag, "_busy"},        {7'b0, bz}, {7'b0, e.busy});
  endtask

  // Drive one cycle of stimulus, record what must appear after the edge,
  // then compare once the DUT has registered its response.
  task automatic step(input int sel, input logic [3:0] rq, input logic fl, input logic mr,
                      input logic [3:0] egv, input logic [2:0] ecnt, input string tag);
    exp_t e;
    e.gv    = egv;
    e.valid = (egv != 4'b0);
    e.cnt   = ecnt;
    e.busy  = (egv != 4'b0);
    e.sel   = sel;
    e.tag   = tag;
    exp_q.push_back(e);
    rqst_in   = rq;
    flush     = fl;
    mem_ready = mr;
    @(posedge sys_clk);
    #1;
    e = exp_q.pop_front();
    compare_all(e);
  endtask

  task automatic reset_pulse();
    rqst_in   = 4'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    exp_t r;
    rst       = 1'b1;
    rqst_in   = 4'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    #12;
    r.gv = 4'b0; r.valid = 1'b0; r.cnt = 3'd0; r.busy = 1'b0; r.sel = 0; r.tag = "reset";
    compare_all(r);
    rst = 1'b0;

    // single request
    step(0, 4'b0100, 0, 1, 4'b0100, 3'd1, "single_grant");
    step(0, 4'b0000, 0, 1, 4'b0000, 3'd0, "single_done");

    // all requesters held, one grant per cycle
    reset_pulse();
    step(0, 4'b1111, 0, 1, 4'b0001, 3'd4, "rr0");
    step(0, 4'b1111, 0, 1, RR ? 4'b0010 : 4'b0001, 3'd4, "rr1");
    step(0, 4'b1111, 0, 1, RR ? 4'b0100 : 4'b0001, 3'd4, "rr2");
    step(0, 4'b1111, 0, 1, RR ? 4'b1000 : 4'b0001, 3'd4, "rr3");
    step(0, 4'b1111, 0, 1, 4'b0001, 3'd4, "rr4");
    step(0, 4'b1111, 0, 1, RR ? 4'b0010 : 4'b0001, 3'd4, "rr5");
    step(0, 4'b0000, 0, 0, RR ? 4'b0010 : 4'b0001, 3'd4, "rr_stall");

    // flush with mem_ready and requests in the same cycle
    step(0, 4'b1111, 1, 1, 4'b0000, 3'd0, "flush");
    step(0, 4'b0101, 0, 0, RR ? 4'b0100 : 4'b0001, 3'd2, "post_flush_ptr");
    step(0, 4'b0000, 0, 1, RR ? 4'b0001 : 4'b0100, 3'd1, "post_flush_next");
    step(0, 4'b0000, 0, 1, 4'b0000, 3'd0, "post_flush_idle");

    // re-request on the retiring bit
    step(0, 4'b0110, 0, 0, 4'b0010, 3'd2, "rereq_a");
    step(0, 4'b0000, 0, 1, 4'b0100, 3'd1, "rereq_b");
    step(0, 4'b1100, 0, 1, RR ? 4'b1000 : 4'b0100, 3'd2, "rereq_c");
    step(0, 4'b0000, 0, 1, RR ? 4'b0100 : 4'b1000, 3'd1, "rereq_d");
    step(0, 4'b0000, 0, 1, 4'b0000, 3'd0, "rereq_idle");

    // back-pressure
    reset_pulse();
    step(0, 4'b0010, 0, 0, 4'b0010, 3'd1, "bp_grant");
    step(0, 4'b0001, 0, 0, 4'b0010, 3'd2, "bp_stall1");
    step(0, 4'b0000, 0, 0, 4'b0010, 3'd2, "bp_stall2");
    step(0, 4'b0000, 0, 0, 4'b0010, 3'd2, "bp_stall3");
    step(0, 4'b0000, 0, 1, 4'b0001, 3'd1, "bp_wrap");
    step(0, 4'b0000, 0, 1, 4'b0000, 3'd0, "bp_idle");

    // dual grant
    reset_pulse();
    step(1, 4'b1011, 0, 1, 4'b0011, 3'd3, "dual_a");
    step(1, 4'b0000, 0, 1, 4'b1000, 3'd1, "dual_b");
    step(1, 4'b0000, 0, 1, 4'b0000, 3'd0, "dual_idle");
    step(1, 4'b1111, 0, 1, 4'b0011, 3'd4, "dual_rr0");
    step(1, 4'b1111, 0, 1, RR ? 4'b1100 : 4'b0011, 3'd4, "dual_rr1");
    step(1, 4'b1111, 0, 1, 4'b0011, 3'd4, "dual_rr2");
    step(1, 4'b0000, 0, 1, 4'b1100, 3'd2, "dual_drain");
    step(1, 4'b0000, 0, 1, 4'b0000, 3'd0, "dual_end");

    // asynchronous reset while a grant is outstanding
    reset_pulse();
    step(0, 4'b1111, 0, 0, 4'b0001, 3'd4, "pre_async");
    rst = 1'b1;
    #1;
    r.gv = 4'b0; r.valid = 1'b0; r.cnt = 3'd0; r.busy = 1'b0; r.sel = 0; r.tag = "async_rst";
    compare_all(r);
    #2;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
